rle_pair_scheduler: RTL and testbench

RLE_PAIR_SCHEDULER -- requirements
Module: rle_pair_scheduler

---
 rtl/rle_pkg.sv | 37 +++
 rtl/seg8_summarize.sv | 46 ++++
 rtl/rle_pair_scheduler.sv | 151 +++++++++++++++
 tb/tb_rle_pair_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared widths, entry encoding helpers and the 8-coefficient segment summary
// used by the RLE pair scheduler and its segment summarizer.
package rle_pkg;
  localparam int COEF_W   = 12;
  localparam int ENT_W    = 14;
  localparam int SEG_N    = 8;
  localparam int KIND_BIT = 13;
  localparam int RUN_HI   = 4;
  localparam int RUN_LO   = 0;
  localparam int RUN_W    = RUN_HI - RUN_LO + 1;

  // Entries are packed newest-in-LSBs, so appending is a left shift plus OR.
  typedef struct packed {
    logic [3:0]             left;
    logic [3:0]             right;
    logic                   flag;
    logic [3:0]             size;
    logic [SEG_N*ENT_W-1:0] array;
  } seg_sum_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } sched_state_e;

  function automatic logic [ENT_W-1:0] run_entry(input logic [RUN_W-1:0] len);
    logic [ENT_W-1:0] e;
    e = '0;
    e[KIND_BIT] = 1'b1;
    e[RUN_HI:RUN_LO] = len;
    return e;
  endfunction

  function automatic logic [ENT_W-1:0] coef_entry(input logic [COEF_W-1:0] c);
    return {1'b0, {(ENT_W-1-COEF_W){c[COEF_W-1]}}, c};
  endfunction
endpackage

// File: rtl/seg8_summarize.sv
// Combinational summary of one 8-coefficient zigzag segment: leading/trailing
// zero counts, nonzero flag and the ordered entry list with interior zero-runs.
module seg8_summarize
  import rle_pkg::*;
(
  input  logic [SEG_N*COEF_W-1:0] seg_coef,
  output seg_sum_t                seg_sum
);
  logic                   seen;
  logic [3:0]             zrun;
  logic [3:0]             lead;
  logic [3:0]             cnt;
  logic [SEG_N*ENT_W-1:0] arr;
  logic [COEF_W-1:0]      c;

  always_comb begin
    seen = 1'b0;
    zrun = '0;
    lead = '0;
    cnt  = '0;
    arr  = '0;
    c    = '0;
    for (int i = 0; i < SEG_N; i++) begin
      c = seg_coef[i*COEF_W +: COEF_W];
      if (c != '0) begin
        // A run is only emitted between two nonzeros; edge zeros go to left/right.
        if (seen && (zrun != 4'd0)) begin
          arr = {arr[(SEG_N-1)*ENT_W-1:0], run_entry(RUN_W'(zrun))};
          cnt = cnt + 4'd1;
        end
        arr  = {arr[(SEG_N-1)*ENT_W-1:0], coef_entry(c)};
        cnt  = cnt + 4'd1;
        seen = 1'b1;
        zrun = '0;
      end else begin
        zrun = zrun + 4'd1;
        if (!seen) lead = lead + 4'd1;
      end
    end
    seg_sum.left  = seen ? lead : 4'd0;
    seg_sum.right = seen ? zrun : 4'd0;
    seg_sum.flag  = seen;
    seg_sum.size  = cnt;
    seg_sum.array = arr;
  end
endmodule

// File: rtl/rle_pair_scheduler.sv
// Pairs consecutive 8-coefficient segment summaries into 16-coefficient RLE
// records with a one-deep output register and a 4-record block counter.
module rle_pair_scheduler #(
  parameter int COEF_W = rle_pkg::COEF_W,
  parameter int ENT_W  = rle_pkg::ENT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8*COEF_W-1:0]        in_coef,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_left,
  output logic [3:0]                 out_right,
  output logic                       out_flag,
  output logic [16*ENT_W-1:0]        out_array,
  output logic [4:0]                 out_size,
  output logic                       out_last,
  output rle_pkg::sched_state_e      dbg_state
);
  localparam int OUT_W = 16 * ENT_W;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds its payload stable while valid is high and ready is low.
  rle_pkg::seg_sum_t     in_sum, half_q, half_d;
  rle_pkg::sched_state_e state_q, state_d;
  logic [1:0]            pair_cnt_q, pair_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [3:0]            out_left_q, out_left_d, out_right_q, out_right_d;
  logic                  out_flag_q, out_flag_d, out_last_q, out_last_d;
  logic [4:0]            out_size_q, out_size_d;
  logic [OUT_W-1:0]      out_array_q, out_array_d;
  logic                  accept;

  logic [3:0]            m_left, m_right;
  logic                  m_flag, has_run;
  logic [4:0]            m_size, run_len;
  logic [OUT_W-1:0]      m_array;

  seg8_summarize u_sum (
    .seg_coef (in_coef),
    .seg_sum  (in_sum)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Merge held left half with the incoming right half.
  always_comb begin
    run_len = {1'b0, half_q.right} + {1'b0, in_sum.left};
    has_run = (run_len != 5'd0);
    m_left  = '0;
    m_right = '0;
    m_flag  = 1'b0;
    m_size  = '0;
    m_array = '0;
    case ({half_q.flag, in_sum.flag})
      2'b11: begin
        m_left  = half_q.left;
        m_right = in_sum.right;
        m_flag  = 1'b1;
        m_array = OUT_W'(half_q.array);
        if (has_run) m_array = {m_array[OUT_W-ENT_W-1:0], rle_pkg::run_entry(run_len)};
        m_array = (m_array << (int'(in_sum.size) * ENT_W)) | OUT_W'(in_sum.array);
        m_size  = {1'b0, half_q.size} + {1'b0, in_sum.size} + {4'd0, has_run};
      end
      2'b01: begin
        m_left  = 4'd8 + in_sum.left;
        m_right = in_sum.right;
        m_flag  = 1'b1;
        m_array = OUT_W'(in_sum.array);
        m_size  = {1'b0, in_sum.size};
      end
      2'b10: begin
        m_left  = half_q.left;
        m_right = half_q.right + 4'd8;
        m_flag  = 1'b1;
        m_array = OUT_W'(half_q.array);
        m_size  = {1'b0, half_q.size};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    pair_cnt_d  = pair_cnt_q;
    out_valid_d = out_valid_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    out_flag_d  = out_flag_q;
    out_size_d  = out_size_q;
    out_array_d = out_array_q;
    out_last_d  = out_last_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept) begin
      if (state_q == rle_pkg::ST_EMPTY) begin
        half_d  = in_sum;
        state_d = rle_pkg::ST_HALF;
      end else begin
        // A load wins over a same-cycle drain, keeping out_valid high.
        out_valid_d = 1'b1;
        out_left_d  = m_left;
        out_right_d = m_right;
        out_flag_d  = m_flag;
        out_size_d  = m_size;
        out_array_d = m_array;
        out_last_d  = (pair_cnt_q == 2'd3);
        pair_cnt_d  = pair_cnt_q + 2'd1;
        state_d     = rle_pkg::ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= rle_pkg::ST_EMPTY;
      half_q      <= '0;
      pair_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_flag_q  <= 1'b0;
      out_size_q  <= '0;
      out_array_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      pair_cnt_q  <= pair_cnt_d;
      out_valid_q <= out_valid_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_flag_q  <= out_flag_d;
      out_size_q  <= out_size_d;
      out_array_q <= out_array_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_flag  = out_flag_q;
  assign out_size  = out_size_q;
  assign out_array = out_array_q;
  assign out_last  = out_last_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_rle_pair_scheduler.sv
// Directed self-checking bench for rle_pair_scheduler: hand-computed records,
// back-to-back throughput, output stall and mid-pair reset.
module tb_rle_pair_scheduler;
  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [95:0]           in_coef;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            out_left;
  logic [3:0]            out_right;
  logic                  out_flag;
  logic [223:0]          out_array;
  logic [4:0]            out_size;
  logic                  out_last;
  rle_pkg::sched_state_e dbg_state;

  int n_checks;
  int n_fail;
  int exp_pair;

  rle_pair_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_left  (out_left),
    .out_right (out_right),
    .out_flag  (out_flag),
    .out_array (out_array),
    .out_size  (out_size),
    .out_last  (out_last),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] seg(input int c0, input int c1, input int c2, input int c3,
                                      input int c4, input int c5, input int c6, input int c7);
    int c[8];
    logic [95:0] r;
    c = '{c0, c1, c2, c3, c4, c5, c6, c7};
    r = '0;
    for (int i = 0; i < 8; i++) r[i*12 +: 12] = 12'(c[i]);
    return r;
  endfunction

  // Driver tasks
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pair = 0;
  endtask

  task automatic send(input logic [95:0] s);
    in_valid = 1'b1;
    in_coef  = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_coef  = '0;
  endtask

  function automatic logic take_last();
    logic l;
    l = (exp_pair == 3);
    exp_pair = (exp_pair + 1) % 4;
    return l;
  endfunction

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset.out_valid got %0b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset.in_ready got %0b want 1", in_ready); end
    n_checks++; if (dbg_state !== rle_pkg::ST_EMPTY) begin n_fail++; $display("FAIL reset.state got %0d want 0", dbg_state); end
    n_checks++; if ({out_left, out_right, out_flag, out_size, out_last} !== 15'd0) begin n_fail++;
      $display("FAIL reset.fields got %h want 0", {out_left, out_right, out_flag, out_size, out_last}); end
    n_checks++; if (out_array !== 224'd0) begin n_fail++; $display("FAIL reset.array got %h want 0", out_array); end
  endtask

  task automatic test_all_zero();
    logic l;
    send(seg(0, 0, 0, 0, 0, 0, 0, 0));
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero.valid_after_left got %0b want 0", out_valid); end
    n_checks++; if (dbg_state !== rle_pkg::ST_HALF) begin n_fail++; $display("FAIL zero.state_half got %0d want 1", dbg_state); end
    send(seg(0, 0, 0, 0, 0, 0, 0, 0));
    l = take_last();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zero.valid got %0b want 1", out_valid); end
    n_checks++; if ({out_left, out_right, out_flag, out_size} !== 14'd0) begin n_fail++;
      $display("FAIL zero.fields got %h want 0", {out_left, out_right, out_flag, out_size}); end
    n_checks++; if (out_array !== 224'd0) begin n_fail++; $display("FAIL zero.array got %h want 0", out_array); end
    n_checks++; if (out_last !== l) begin n_fail++; $display("FAIL zero.last got %0b want %0b", out_last, l); end
  endtask

  task automatic test_run_merge();
    logic [223:0] exp_arr;
    logic l;
    exp_arr = '0;
    exp_arr[13:0]  = 14'h1FFD;
    exp_arr[27:14] = 14'h200E;
    exp_arr[41:28] = 14'h0005;
    send(seg(5, 0, 0, 0, 0, 0, 0, 0));
    send(seg(0, 0, 0, 0, 0, 0, 0, -3));
    l = take_last();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL run.valid got %0b want 1", out_valid); end
    n_checks++; if (out_left !== 4'd0 || out_right !== 4'd0) begin n_fail++;
      $display("FAIL run.left_right got %0d/%0d want 0/0", out_left, out_right); end
    n_checks++; if (out_flag !== 1'b1) begin n_fail++; $display("FAIL run.flag got %0b want 1", out_flag); end
    n_checks++; if (out_size !== 5'd3) begin n_fail++; $display("FAIL run.size got %0d want 3", out_size); end
    n_checks++; if (out_array !== exp_arr) begin n_fail++; $display("FAIL run.array got %h want %h", out_array, exp_arr); end
    n_checks++; if (out_last !== l) begin n_fail++; $display("FAIL run.last got %0b want %0b", out_last, l); end
  endtask

  task automatic test_left_zero();
    logic [223:0] exp_arr;
    logic l;
    exp_arr = '0;
    exp_arr[13:0] = 14'h0007;
    send(seg(0, 0, 0, 0, 0, 0, 0, 0));
    send(seg(0, 0, 7, 0, 0, 0, 0, 0));
    l = take_last();
    n_checks++; if (out_left !== 4'd10) begin n_fail++; $display("FAIL lz.left got %0d want 10", out_left); end
    n_checks++; if (out_right !== 4'd5) begin n_fail++; $display("FAIL lz.right got %0d want 5", out_right); end
    n_checks++; if (out_size !== 5'd1 || out_flag !== 1'b1) begin n_fail++;
      $display("FAIL lz.size_flag got %0d/%0b want 1/1", out_size, out_flag); end
    n_checks++; if (out_array !== exp_arr) begin n_fail++; $display("FAIL lz.array got %h want %h", out_array, exp_arr); end
    n_checks++; if (out_last !== l) begin n_fail++; $display("FAIL lz.last got %0b want %0b", out_last, l); end
  endtask

  task automatic test_back_to_back();
    logic [223:0] exp_arr;
    logic l;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_coef  = seg(k + 1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b.in_ready[%0d] got %0b want 1", k, in_ready); end
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== (k % 2 == 1)) begin n_fail++;
        $display("FAIL b2b.valid[%0d] got %0b want %0b", k, out_valid, (k % 2 == 1)); end
      if (k % 2 == 1) begin
        l = take_last();
        exp_arr = '0;
        exp_arr[13:0]  = 14'(k + 1);
        exp_arr[27:14] = 14'h2007;
        exp_arr[41:28] = 14'(k);
        n_checks++; if (out_last !== l || out_last !== (k == 7)) begin n_fail++;
          $display("FAIL b2b.last[%0d] got %0b want %0b", k, out_last, (k == 7)); end
        n_checks++; if (out_size !== 5'd3 || out_right !== 4'd7) begin n_fail++;
          $display("FAIL b2b.size_right[%0d] got %0d/%0d want 3/7", k, out_size, out_right); end
        n_checks++; if (out_array !== exp_arr) begin n_fail++;
          $display("FAIL b2b.array[%0d] got %h want %h", k, out_array, exp_arr); end
      end
    end
    in_valid = 1'b0;
    in_coef  = '0;
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b.drain got %0b want 0", out_valid); end
  endtask

  task automatic test_stall();
    logic [223:0] exp_arr;
    logic l;
    exp_arr = '0;
    exp_arr[13:0]  = 14'h0002;
    exp_arr[27:14] = 14'h0001;
    out_ready = 1'b0;
    send(seg(1, 2, 0, 0, 0, 0, 0, 0));
    send(seg(0, 0, 0, 0, 0, 0, 0, 0));
    l = take_last();
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++;
        $display("FAIL stall.valid_ready[%0d] got %0b/%0b want 1/0", c, out_valid, in_ready); end
      n_checks++; if (out_left !== 4'd0 || out_right !== 4'd14 || out_size !== 5'd2 || out_last !== l) begin n_fail++;
        $display("FAIL stall.fields[%0d] got %0d/%0d/%0d/%0b want 0/14/2/%0b", c, out_left, out_right, out_size, out_last, l); end
      n_checks++; if (out_array !== exp_arr) begin n_fail++;
        $display("FAIL stall.array[%0d] got %h want %h", c, out_array, exp_arr); end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall.release_ready got %0b want 1", in_ready); end
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall.cleared got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic l;
    send(seg(9, 0, 0, 0, 0, 0, 0, 0));
    n_checks++; if (dbg_state !== rle_pkg::ST_HALF) begin n_fail++; $display("FAIL rmid.half got %0d want 1", dbg_state); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pair = 0;
    n_checks++; if (dbg_state !== rle_pkg::ST_EMPTY || in_ready !== 1'b1) begin n_fail++;
      $display("FAIL rmid.after_rst got %0d/%0b want 0/1", dbg_state, in_ready); end
    for (int p = 0; p < 4; p++) begin
      send(seg(0, 0, 0, 0, 0, 0, 0, 0));
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid.left_only[%0d] got %0b want 0", p, out_valid); end
      send(seg(0, 0, 7, 0, 0, 0, 0, 0));
      l = take_last();
      n_checks++; if (out_left !== 4'd10 || out_right !== 4'd5 || out_size !== 5'd1) begin n_fail++;
        $display("FAIL rmid.fields[%0d] got %0d/%0d/%0d want 10/5/1", p, out_left, out_right, out_size); end
      n_checks++; if (out_last !== l || out_last !== (p == 3)) begin n_fail++;
        $display("FAIL rmid.last[%0d] got %0b want %0b", p, out_last, (p == 3)); end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_pair  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_coef   = '0;
    out_ready = 1'b1;
    test_reset();
    test_all_zero();
    test_run_merge();
    test_left_zero();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
